// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg
// Shared constants and types for the instruction-fetch stage: FSM state
// encoding, instruction width, default NOP encoding and the 16-bit PC adder.
// No ports.
package fetch_pc_unit_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [ADDR_W-1:0]  PC_STEP       = 16'd2;

  // state     | meaning
  // IDLE      | out of reset, first request issued next cycle
  // FETCH     | request outstanding at reqAddr, consuming responses
  // HOLD      | response captured in skid buffer while stalled
  // DRAIN     | redirected with a request in flight; discard its response
  // HALTED    | HALT seen; frozen until reset
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    HOLD   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } fetchState_e;

  // The shared 16-bit adder; wraps naturally (0xFFFE + 2 = 0x0000).
  function automatic logic [ADDR_W-1:0] add16(input logic [ADDR_W-1:0] a,
                                              input logic [ADDR_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
// Instruction-memory request/response handshake.
//   imem_req   : fetch request valid (fetch side drives)
//   imem_addr  : fetch address, stable while imem_req=1 until imem_ready
//   imem_ready : imem_data valid this cycle (memory side drives)
//   imem_data  : fetched instruction
// Modports: master = fetch unit, slave = instruction memory.
interface fetch_pc_unit_if;
  import fetch_pc_unit_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );

endinterface

// File: rtl/fetch_pc_unit_ifid.sv
// ifid_reg
// IF/ID pipeline register with load / hold / flush controls.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture instrIn / pcPlus2In and mark valid
//   flush           : insert a bubble (NOP, valid=0); wins over load
//   instrIn         : instruction to capture
//   pcPlus2In       : PC+2 of that instruction
//   instr, pcPlus2  : registered IF/ID contents
//   valid           : IF/ID holds a real instruction
// Neither load nor flush means hold.
module ifid_reg
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [ADDR_W-1:0]  pcPlus2In,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pcPlus2,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= NOP;
      pcPlus2 <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      // pcPlus2 is left as-is; it is meaningless while valid=0
      instr <= NOP;
      valid <= 1'b0;
    end else if (load) begin
      instr   <= instrIn;
      pcPlus2 <= pcPlus2In;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Instruction-fetch stage: owns the architectural PC, issues requests to
// instruction memory and fills the IF/ID register. Handles EX redirects,
// hazard stalls (with a one-entry skid buffer), HALT, and a variable-latency
// memory handshake.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall             : hold PC and IF/ID
//   redirect          : branch taken / jump from EX (highest priority)
//   redirect_addr     : redirect target; bit 0 is dropped and flagged in err
//   halt              : HALT decoded in ID
//   imem              : instruction-memory handshake (master modport)
//   pc                : current fetch PC
//   ifid_instr        : IF/ID instruction
//   ifid_pc_plus2     : IF/ID PC+2
//   ifid_valid        : IF/ID holds a real instruction
//   err               : sticky misaligned-redirect flag
// Build option FETCH_PERF_CNT_EN adds 16-bit saturating counters
//   perf_fetched, perf_stall_cycles, perf_redirects.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_addr,
  input  logic                halt,
  fetch_pc_unit_if.master     imem,
  output logic [ADDR_W-1:0]   pc,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic [ADDR_W-1:0]   ifid_pc_plus2,
  output logic                ifid_valid,
  output logic                err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         perf_fetched,
  output logic [15:0]         perf_stall_cycles,
  output logic [15:0]         perf_redirects
`endif
);

  fetchState_e        state;
  logic [ADDR_W-1:0]  pcQ;
  logic [ADDR_W-1:0]  reqAddrQ;
  logic [INSTR_W-1:0] skidQ;
  logic               reqQ;
  logic               errQ;
  logic               haltPendQ;

  logic [ADDR_W-1:0]  pcNext;
  logic [ADDR_W-1:0]  target;
  logic               redirectTaken;
  logic               ifidLoad;
  logic               ifidFlush;
  logic [INSTR_W-1:0] ifidInstrIn;

  assign pcNext        = add16(pcQ, PC_STEP);
  assign target        = redirect_addr & 16'hFFFE;
  assign redirectTaken = redirect && (state != HALTED);

  // IF/ID control. A redirect or halt always flushes; DRAIN and HALTED keep
  // the register a bubble so a discarded response can never leak through.
  always_comb begin
    ifidLoad    = 1'b0;
    ifidFlush   = 1'b0;
    ifidInstrIn = imem.imem_data;
    case (state)
      IDLE: begin
        if (redirect) ifidFlush = 1'b1;
      end
      FETCH: begin
        if (redirect || halt)                  ifidFlush = 1'b1;
        else if (imem.imem_ready && !stall)    ifidLoad  = 1'b1;
        else if (!imem.imem_ready && !stall)   ifidFlush = 1'b1;
      end
      HOLD: begin
        if (redirect || halt) begin
          ifidFlush = 1'b1;
        end else if (!stall) begin
          ifidLoad    = 1'b1;
          ifidInstrIn = skidQ;
        end
      end
      DRAIN, HALTED: ifidFlush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcQ       <= RESET_PC;
      reqAddrQ  <= RESET_PC;
      skidQ     <= '0;
      reqQ      <= 1'b0;
      errQ      <= 1'b0;
      haltPendQ <= 1'b0;
    end else begin
      if (redirectTaken) begin
        pcQ <= target;
        if (redirect_addr[0]) errQ <= 1'b1;
      end
      case (state)
        IDLE: begin
          state    <= FETCH;
          reqQ     <= 1'b1;
          reqAddrQ <= redirect ? target : pcQ;
        end
        FETCH: begin
          if (redirect) begin
            // Without a response the old request is still owed to us, so its
            // address must stay on the bus until it completes.
            if (imem.imem_ready) reqAddrQ <= target;
            else                 state    <= DRAIN;
          end else if (halt) begin
            state <= HALTED;
            reqQ  <= 1'b0;
          end else if (imem.imem_ready) begin
            if (stall) begin
              skidQ <= imem.imem_data;
              state <= HOLD;
              reqQ  <= 1'b0;
            end else begin
              pcQ      <= pcNext;
              reqAddrQ <= pcNext;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            state    <= FETCH;
            reqQ     <= 1'b1;
            reqAddrQ <= target;
            skidQ    <= '0;
          end else if (halt) begin
            state <= HALTED;
            skidQ <= '0;
          end else if (!stall) begin
            state    <= FETCH;
            reqQ     <= 1'b1;
            pcQ      <= pcNext;
            reqAddrQ <= pcNext;
          end
        end
        DRAIN: begin
          if (halt && !redirect) haltPendQ <= 1'b1;
          if (imem.imem_ready) begin
            if (haltPendQ || (halt && !redirect)) begin
              state     <= HALTED;
              reqQ      <= 1'b0;
              haltPendQ <= 1'b0;
            end else begin
              state    <= FETCH;
              reqAddrQ <= redirect ? target : pcQ;
            end
          end
        end
        HALTED: ;
        default: begin
          state <= IDLE;
          reqQ  <= 1'b0;
        end
      endcase
    end
  end

  ifid_reg #(
    .NOP (NOP_INSTR)
  ) u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ifidLoad),
    .flush     (ifidFlush),
    .instrIn   (ifidInstrIn),
    .pcPlus2In (pcNext),
    .instr     (ifid_instr),
    .pcPlus2   (ifid_pc_plus2),
    .valid     (ifid_valid)
  );

  assign imem.imem_req  = reqQ;
  assign imem.imem_addr = reqAddrQ;
  assign pc             = pcQ;
  assign err            = errQ;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (ifidLoad && (perf_fetched != 16'hFFFF))
        perf_fetched <= perf_fetched + 16'd1;
      if (stall && ifid_valid && (perf_stall_cycles != 16'hFFFF))
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
      if (redirectTaken && (perf_redirects != 16'hFFFF))
        perf_redirects <= perf_redirects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
// Self-checking bench for fetch_pc_unit: streaming fetch with a scoreboard,
// then a table of per-cycle vectors covering stall/skid, redirect drain,
// misaligned redirect, halt priority, reset mid-halt, PC wrap and halt
// deferred behind a drain.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stallDrv;
  logic        redirectDrv;
  logic [15:0] redirectAddrDrv;
  logic        haltDrv;
  logic        readyDrv;

  logic [15:0] pc;
  logic [15:0] ifidInstr;
  logic [15:0] ifidPcPlus2;
  logic        ifidValid;
  logic        err;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perfFetched;
  logic [15:0] perfStallCycles;
  logic [15:0] perfRedirects;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] raddr;
    logic        halt;
    logic        ready;
    logic [15:0] expPc;
    logic [15:0] expAddr;
    logic        expReq;
    logic [15:0] expInstr;
    logic [15:0] expPp2;
    logic        expValid;
    logic        expErr;
  } vec_t;

  vec_t vecs [17];
  vec_t sbq [$];
  vec_t cur;
  vec_t exp;

  fetch_pc_unit_if bus ();

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3C3;
  endfunction

  assign bus.imem_ready = readyDrv;
  assign bus.imem_data  = memWord(bus.imem_addr);

  fetch_pc_unit #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stallDrv),
    .redirect      (redirectDrv),
    .redirect_addr (redirectAddrDrv),
    .halt          (haltDrv),
    .imem          (bus),
    .pc            (pc),
    .ifid_instr    (ifidInstr),
    .ifid_pc_plus2 (ifidPcPlus2),
    .ifid_valid    (ifidValid),
    .err           (err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched      (perfFetched),
    .perf_stall_cycles (perfStallCycles),
    .perf_redirects    (perfRedirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] ra,
                              input logic h, input logic rdy, input logic [15:0] ePc,
                              input logic [15:0] eAddr, input logic eReq,
                              input logic [15:0] eInstr, input logic [15:0] ePp2,
                              input logic eValid, input logic eErr);
    vec_t v;
    v.stall = s; v.redirect = r; v.raddr = ra; v.halt = h; v.ready = rdy;
    v.expPc = ePc; v.expAddr = eAddr; v.expReq = eReq; v.expInstr = eInstr;
    v.expPp2 = ePp2; v.expValid = eValid; v.expErr = eErr;
    return v;
  endfunction

  // Drive each row at a falling edge, push its expectation, and compare it
  // one rising edge later.
  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      cur             = vecs[i];
      stallDrv        = cur.stall;
      redirectDrv     = cur.redirect;
      redirectAddrDrv = cur.raddr;
      haltDrv         = cur.halt;
      readyDrv        = cur.ready;
      sbq.push_back(cur);
      @(negedge clk);
      exp = sbq.pop_front();
      chk($sformatf("row%0d_pc", i), pc, exp.expPc);
      chk($sformatf("row%0d_req", i), {15'd0, bus.imem_req}, {15'd0, exp.expReq});
      if (exp.expReq)
        chk($sformatf("row%0d_addr", i), bus.imem_addr, exp.expAddr);
      chk($sformatf("row%0d_instr", i), ifidInstr, exp.expInstr);
      chk($sformatf("row%0d_pp2", i), ifidPcPlus2, exp.expPp2);
      chk($sformatf("row%0d_valid", i), {15'd0, ifidValid}, {15'd0, exp.expValid});
      chk($sformatf("row%0d_err", i), {15'd0, err}, {15'd0, exp.expErr});
    end
  endtask

  initial begin
    //             stall redir raddr    halt rdy  pc       addr     req instr              pp2      v  err
    vecs[0]  = mk(1, 0, 16'h0000, 0, 1, 16'h0010, 16'h0010, 0, memWord(16'h000E), 16'h0010, 1, 0);
    vecs[1]  = mk(1, 0, 16'h0000, 0, 1, 16'h0010, 16'h0010, 0, memWord(16'h000E), 16'h0010, 1, 0);
    vecs[2]  = mk(1, 0, 16'h0000, 0, 1, 16'h0010, 16'h0010, 0, memWord(16'h000E), 16'h0010, 1, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 1, 16'h0012, 16'h0012, 1, memWord(16'h0010), 16'h0012, 1, 0);
    vecs[4]  = mk(0, 1, 16'h0100, 0, 0, 16'h0100, 16'h0012, 1, 16'h0800,          16'h0012, 0, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 0, 1, 16'h0100, 16'h0100, 1, 16'h0800,          16'h0012, 0, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 1, 16'h0102, 16'h0102, 1, memWord(16'h0100), 16'h0102, 1, 0);
    vecs[7]  = mk(1, 1, 16'h0041, 0, 1, 16'h0040, 16'h0040, 1, 16'h0800,          16'h0102, 0, 1);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 1, 16'h0042, 16'h0042, 1, memWord(16'h0040), 16'h0042, 1, 1);
    vecs[9]  = mk(0, 1, 16'h0200, 1, 1, 16'h0200, 16'h0200, 1, 16'h0800,          16'h0042, 0, 1);
    vecs[10] = mk(0, 0, 16'h0000, 1, 1, 16'h0200, 16'h0200, 0, 16'h0800,          16'h0042, 0, 1);
    // after reset: wrap, then halt deferred behind a drain
    vecs[11] = mk(0, 1, 16'hFFFE, 0, 1, 16'hFFFE, 16'hFFFE, 1, 16'h0800,          16'h0000, 0, 0);
    vecs[12] = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 1, memWord(16'hFFFE), 16'h0000, 1, 0);
    vecs[13] = mk(0, 1, 16'h0080, 0, 0, 16'h0080, 16'h0000, 1, 16'h0800,          16'h0000, 0, 0);
    vecs[14] = mk(0, 0, 16'h0000, 1, 0, 16'h0080, 16'h0000, 1, 16'h0800,          16'h0000, 0, 0);
    vecs[15] = mk(0, 0, 16'h0000, 0, 1, 16'h0080, 16'h0080, 0, 16'h0800,          16'h0000, 0, 0);
    vecs[16] = mk(0, 1, 16'h0400, 0, 1, 16'h0080, 16'h0080, 0, 16'h0800,          16'h0000, 0, 0);

    rst_n           = 1'b0;
    stallDrv        = 1'b0;
    redirectDrv     = 1'b0;
    redirectAddrDrv = 16'h0000;
    haltDrv         = 1'b0;
    readyDrv        = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_req", {15'd0, bus.imem_req}, 16'h0000);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk("rst_instr", ifidInstr, 16'h0800);
    chk("rst_pp2", ifidPcPlus2, 16'h0000);
    chk("rst_valid", {15'd0, ifidValid}, 16'h0000);
    chk("rst_err", {15'd0, err}, 16'h0000);

    readyDrv = 1'b1;
    rst_n    = 1'b1;

    // Streaming fetch, memory always ready: one instruction per cycle.
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("stream%0d_addr", k), bus.imem_addr, 16'(2 * k));
      chk($sformatf("stream%0d_pc", k), pc, 16'(2 * k));
      chk($sformatf("stream%0d_req", k), {15'd0, bus.imem_req}, 16'h0001);
      if (k > 0) begin
        exp = sbq.pop_front();
        chk($sformatf("stream%0d_instr", k), ifidInstr, exp.expInstr);
        chk($sformatf("stream%0d_pp2", k), ifidPcPlus2, exp.expPp2);
        chk($sformatf("stream%0d_valid", k), {15'd0, ifidValid}, 16'h0001);
      end else begin
        chk("stream0_valid", {15'd0, ifidValid}, 16'h0000);
      end
      if (k < 8) begin
        cur          = mk(0, 0, 16'h0, 0, 1, 16'h0, 16'h0, 1, 16'h0, 16'h0, 1, 0);
        cur.expInstr = memWord(bus.imem_addr);
        cur.expPp2   = bus.imem_addr + 16'd2;
        sbq.push_back(cur);
      end
    end

    runRows(0, 10);

    // HALTED: frozen, redirect ignored.
    for (int k = 0; k < 10; k++) begin
      redirectDrv     = 1'b1;
      redirectAddrDrv = 16'h0300;
      haltDrv         = 1'b0;
      @(negedge clk);
      chk($sformatf("halted%0d_pc", k), pc, 16'h0200);
      chk($sformatf("halted%0d_req", k), {15'd0, bus.imem_req}, 16'h0000);
      chk($sformatf("halted%0d_valid", k), {15'd0, ifidValid}, 16'h0000);
    end

    // Reset asserted mid-halt takes effect without a clock edge.
    redirectDrv = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_req", {15'd0, bus.imem_req}, 16'h0000);
    chk("mid_rst_err", {15'd0, err}, 16'h0000);
    chk("mid_rst_instr", ifidInstr, 16'h0800);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", {15'd0, bus.imem_req}, 16'h0001);
    chk("restart_addr", bus.imem_addr, 16'h0000);
    chk("restart_pc", pc, 16'h0000);

    runRows(11, 16);

    chk("sbq_empty", 16'(sbq.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
